// File: rtl/fb_tap_sequencer_if.sv
// Serial tap stream between the delay-line sequencer (master) and a time-shared MAC (slave).
// Widths must match the sequencer's IDX_W and tap output width.
interface fb_tap_sequencer_if #(
    parameter int IDX_W = 7,
    parameter int OUT_W = 11
);
    logic                    tap_ready;
    logic                    tap_valid;
    logic [IDX_W-1:0]        tap_idx;
    logic signed [OUT_W-1:0] tap_data;
    logic                    tap_first;
    logic                    tap_last;

    modport master (
        input  tap_ready,
        output tap_valid, tap_idx, tap_data, tap_first, tap_last
    );

    modport slave (
        output tap_ready,
        input  tap_valid, tap_idx, tap_data, tap_first, tap_last
    );
endinterface

// File: rtl/fb_tap_sequencer.sv
// Decimated input delay line, phase counter and serial tap streamer for a time-shared MAC.
// Optional macro FB_TAP_FOLD_EN streams pre-added symmetric tap pairs (OUT_W = DATA_W+1).
module fb_tap_sequencer #(
    parameter int DATA_W = 11,
    parameter int TAPS   = 119,
    parameter int DECIM  = 56,
    parameter int IDX_W  = $clog2(TAPS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic signed [DATA_W-1:0] filter_in,
    output logic                     phase_tick,
    output logic                     busy,
    output logic                     overrun,
    fb_tap_sequencer_if.master       tap
);
`ifdef FB_TAP_FOLD_EN
    localparam int OUT_W = DATA_W + 1;
    localparam int LAST  = (TAPS + 1) / 2 - 1;
`else
    localparam int OUT_W = DATA_W;
    localparam int LAST  = TAPS - 1;
`endif
    localparam int PH_W = $clog2(DECIM);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                    state_q, state_d;
    logic [PH_W-1:0]           phase_q, phase_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [DATA_W-1:0]  pend_q, pend_d;
    logic                      pend_v_q, pend_v_d;
    logic                      overrun_q, overrun_d;
    logic signed [DATA_W-1:0]  line_q [TAPS];
    logic                      shift_en;
    logic signed [DATA_W-1:0]  shift_val;
    logic                      xfer, at_last;

    assign phase_tick = clk_enable && (phase_q == PH_W'(DECIM - 1));
    assign xfer       = (state_q == STREAM) && tap.tap_ready;
    assign at_last    = (idx_q == IDX_W'(LAST));

    always_comb begin
        phase_d   = phase_q;
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        overrun_d = overrun_q;
        shift_en  = 1'b0;
        shift_val = filter_in;
        if (clk_enable) begin
            phase_d = phase_tick ? '0 : phase_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (phase_tick) begin
                    shift_en = 1'b1;
                    state_d  = STREAM;
                    idx_d    = '0;
                end
            end
            STREAM: begin
                if (xfer && at_last) begin
                    idx_d = '0;
                    // Pending sample goes into the line before any sample arriving on this edge.
                    if (pend_v_q) begin
                        shift_en  = 1'b1;
                        shift_val = pend_q;
                        pend_v_d  = phase_tick;
                        if (phase_tick) pend_d = filter_in;
                    end else if (phase_tick) begin
                        shift_en = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) idx_d = idx_q + 1'b1;
                    if (phase_tick) begin
                        if (pend_v_q) overrun_d = 1'b1;
                        pend_d   = filter_in;
                        pend_v_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            idx_q     <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) line_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            overrun_q <= overrun_d;
            if (shift_en) begin
                line_q[0] <= shift_val;
                for (int k = 1; k < TAPS; k++) line_q[k] <= line_q[k-1];
            end
        end
    end

    logic signed [OUT_W-1:0] tap_data_w;
`ifdef FB_TAP_FOLD_EN
    localparam logic [IDX_W-1:0] MIR_BASE = IDX_W'(TAPS - 1);
    localparam logic [IDX_W-1:0] CENTRE   = IDX_W'((TAPS - 1) / 2);
    logic [IDX_W-1:0]         mir_idx;
    logic signed [DATA_W-1:0] near_s, far_s;
    logic signed [OUT_W-1:0]  near_x, far_x;
    assign mir_idx = MIR_BASE - idx_q;
    assign near_s  = line_q[idx_q];
    assign far_s   = line_q[mir_idx];
    assign near_x  = {near_s[DATA_W-1], near_s};
    assign far_x   = {far_s[DATA_W-1], far_s};
    // With odd TAPS the centre tap has no partner and is passed through alone.
    assign tap_data_w = ((TAPS % 2) == 1 && idx_q == CENTRE) ? near_x : near_x + far_x;
`else
    assign tap_data_w = line_q[idx_q];
`endif

    assign tap.tap_valid = (state_q == STREAM);
    assign tap.tap_idx   = idx_q;
    assign tap.tap_data  = tap_data_w;
    assign tap.tap_first = (state_q == STREAM) && (idx_q == '0);
    assign tap.tap_last  = (state_q == STREAM) && at_last;
    assign busy          = (state_q != IDLE);
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_fb_tap_sequencer.sv
// Scoreboard bench for fb_tap_sequencer: stimulus pushes expected taps, a monitor pops on transfers.
// Works in both the default build and with FB_TAP_FOLD_EN defined.
module tb_fb_tap_sequencer;
    localparam int DATA_W = 11;
    localparam int TAPS   = 119;
    localparam int DECIM  = 56;
    localparam int IDX_W  = $clog2(TAPS);
`ifdef FB_TAP_FOLD_EN
    localparam int OUT_W = DATA_W + 1;
    localparam int LAST  = (TAPS + 1) / 2 - 1;
`else
    localparam int OUT_W = DATA_W;
    localparam int LAST  = TAPS - 1;
`endif
    localparam int FRAME = LAST + 1;

    typedef struct {
        int idx;
        int data;
        bit first;
        bit last;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic clk_enable = 1'b0;
    logic signed [DATA_W-1:0] filter_in = '0;
    logic tap_ready = 1'b0;
    logic phase_tick, busy, overrun;

    int checks = 0;
    int failures = 0;
    exp_t sb_q[$];
    int m_line[TAPS];

    fb_tap_sequencer_if #(.IDX_W(IDX_W), .OUT_W(OUT_W)) tif ();
    assign tif.tap_ready = tap_ready;

    fb_tap_sequencer #(.DATA_W(DATA_W), .TAPS(TAPS), .DECIM(DECIM), .IDX_W(IDX_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .clk_enable (clk_enable),
        .filter_in  (filter_in),
        .phase_tick (phase_tick),
        .busy       (busy),
        .overrun    (overrun),
        .tap        (tif.master)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Shift a sample into the reference line and queue the frame it will stream.
    task automatic push_frame(input int sample);
        exp_t e;
        for (int k = TAPS - 1; k > 0; k--) m_line[k] = m_line[k-1];
        m_line[0] = sample;
        for (int i = 0; i <= LAST; i++) begin
            e.idx = i;
`ifdef FB_TAP_FOLD_EN
            if ((TAPS % 2) == 1 && i == (TAPS - 1) / 2) e.data = m_line[i];
            else e.data = m_line[i] + m_line[TAPS-1-i];
`else
            e.data = m_line[i];
`endif
            e.first = (i == 0);
            e.last  = (i == LAST);
            sb_q.push_back(e);
        end
    endtask

    // Entered and left just after a rising edge; returns after the shift edge with clk_enable low.
    task automatic run_to_tick(input int sample, input bit ready_at_tick);
        int n_cyc;
        n_cyc = 0;
        clk_enable = 1'b1;
        filter_in  = DATA_W'(sample);
        for (int n = 1; n <= DECIM + 4; n++) begin
            if (n == DECIM && ready_at_tick) tap_ready = 1'b1;
            @(negedge clock);
            if (phase_tick) begin
                n_cyc = n;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        clk_enable = 1'b0;
        check("tick_interval", n_cyc, DECIM);
    endtask

    task automatic wait_idle(input bit toggle, output int edges);
        edges = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (!busy) begin
                edges = k;
                break;
            end
            @(posedge clock); #1;
            if (toggle) tap_ready = ~tap_ready;
        end
        @(posedge clock); #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        sb_q.delete();
        for (int k = 0; k < TAPS; k++) m_line[k] = 0;
        @(negedge clock);
        check({tag, "_valid"}, int'(tif.tap_valid), 0);
        check({tag, "_first"}, int'(tif.tap_first), 0);
        check({tag, "_last"},  int'(tif.tap_last), 0);
        check({tag, "_idx"},   int'(tif.tap_idx), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_ovr"},   int'(overrun), 0);
        check({tag, "_tick"},  int'(phase_tick), 0);
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    // Monitor: every valid cycle must match the queue head; the head is popped on a transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && tif.tap_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tap actual_idx=%0d required=none", tif.tap_idx);
                end else begin
                    e = sb_q[0];
                    checks++;
                    if (int'(tif.tap_idx) != e.idx || int'(tif.tap_data) != e.data ||
                        tif.tap_first != e.first || tif.tap_last != e.last) begin
                        failures++;
                        $display("FAIL tap actual idx=%0d data=%0d first=%0b last=%0b required idx=%0d data=%0d first=%0b last=%0b",
                                 tif.tap_idx, tif.tap_data, tif.tap_first, tif.tap_last,
                                 e.idx, e.data, e.first, e.last);
                    end
                    if (tap_ready) begin
                        $display("tap idx=%0d data=%0d first=%0b last=%0b", tif.tap_idx, tif.tap_data,
                                 tif.tap_first, tif.tap_last);
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        for (int k = 0; k < TAPS; k++) m_line[k] = 0;
        repeat (3) @(posedge clock);
        #1;
        do_reset("rst");

        // Single frame at full rate.
        tap_ready = 1'b1;
        push_frame(5);
        run_to_tick(5, 1'b0);
        wait_idle(1'b0, e);
        check("frame_cycles_full", e, FRAME);

        // Backpressure: ready toggles every cycle, starting low.
        tap_ready = 1'b0;
        push_frame(-2);
        run_to_tick(-2, 1'b0);
        wait_idle(1'b1, e);
        check("frame_cycles_bp", e, 2 * FRAME);

        // Last transfer coincides with a tick while a sample is pending.
        do_reset("rst2");
        tap_ready = 1'b0;
        push_frame(3);
        run_to_tick(3, 1'b0);
        push_frame(-4);
        run_to_tick(-4, 1'b0);
        check("sim_ovr_pend", int'(overrun), 0);
        tap_ready = 1'b1;
        repeat (LAST) @(posedge clock);
        #1;
        tap_ready = 1'b0;
        push_frame(9);
        run_to_tick(9, 1'b1);
        check("sim_ovr_tick", int'(overrun), 0);
        check("sim_busy", int'(busy), 1);
        wait_idle(1'b0, e);
        check("sim_two_frames", e, 2 * FRAME);
        check("sim_ovr_end", int'(overrun), 0);

        // Two ticks while stalled: the second pending sample overwrites the first.
        tap_ready = 1'b0;
        push_frame(2);
        run_to_tick(2, 1'b0);
        run_to_tick(-3, 1'b0);
        check("ovr_first_pend", int'(overrun), 0);
        run_to_tick(7, 1'b0);
        check("ovr_set", int'(overrun), 1);
        push_frame(7);
        tap_ready = 1'b1;
        wait_idle(1'b0, e);
        check("ovr_two_frames", e, 2 * FRAME);
        check("ovr_sticky", int'(overrun), 1);

        // Reset in the middle of a frame.
        push_frame(6);
        run_to_tick(6, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        check("mid_busy", int'(busy), 1);
        do_reset("mid_rst");

`ifdef FB_TAP_FOLD_EN
        // Oldest and newest samples of a full line both -1024: idx 0 sums to -2048.
        tap_ready = 1'b1;
        for (int k = 0; k < TAPS; k++) begin
            push_frame((k == 0 || k == TAPS - 1) ? -1024 : 0);
            run_to_tick((k == 0 || k == TAPS - 1) ? -1024 : 0, 1'b0);
            wait_idle(1'b0, e);
            if (k == TAPS - 1) check("fold_frame_cycles", e, FRAME);
        end
        check("fold_ovr", int'(overrun), 0);
`endif

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
